exe_stage: RTL and testbench
============================

# exe_stage

Pipelined RV32IM execute stage, the parametrised successor to the combinational execute block. It selects ALU operands, performs single-cycle integer ops and iterative multiply/divide, and resolves branches. Results are registered behind a valid/ready handshake. It sits between decode/register-read and memory/writeback, and accepts a kill from the front end for mispredict flush.

## Interface
- WIDTH, 32: datapath width; must be a power of two, ≥ 8
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- kill  in  1  abort the in-flight op and drop the registered output
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage can accept
- pc, rd1, rd2, imm  in  WIDTH each  operands
- alua_sel  in  2  operand A select: 01 zero, 10 pc, else rd1
- alub_sel  in  2  operand B select: 00 rd2, 01 rd2 & (WIDTH-1), 10 imm, 11 constant 4
- op  in  5  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 16–23 MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; others illegal → result 0
- branch_cntr  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  WIDTH  op result
- pcbranch  out  1  branch taken; meaningful only while out_valid
- branch_target  out  WIDTH  pc + imm, modulo 2^WIDTH
- busy  out  1  multi-cycle op in progress

## Operation
- Accept when in_valid && in_ready && !kill. in_ready = !rst && state==IDLE && (!out_valid || out_ready).
- Single-cycle ops (0–9): result, pcbranch and branch_target are registered on the accept edge. out_valid is set on the same edge.
- Shift ops use b[$clog2(WIDTH)-1:0] only. SLT/SLTU produce 0 or 1, zero-extended.
- Branch compares use rd1 vs rd2 directly, independent of the operand muxes. For ops ≥ 16, pcbranch is 0.
- Multiply/divide FSM:
  - IDLE → CALC on accepting op ≥ 16. Signed operands are converted to magnitudes, counter loads WIDTH, busy=1.
  - CALC performs one shift-add (mul) or restoring subtract (div) step per cycle and decrements the counter. At 0 it moves to FIN.
  - FIN applies sign correction, selects the high/low half or quotient/remainder, writes the output registers, sets out_valid and moves to IDLE.
- Divide by zero: quotient all-ones, remainder = dividend.
- Signed overflow (−2^(WIDTH−1) / −1): quotient = dividend, remainder 0.
- Both special cases keep the normal latency.
- Output hold: while out_valid && !out_ready, all outputs stay stable and no new op is accepted.
- kill: on the edge it is sampled, out_valid←0, state←IDLE, busy←0, and any input presented that cycle is not accepted. Result registers may keep stale data.
- rst: out_valid 0, result 0, pcbranch 0, branch_target 0, busy 0, state IDLE, counter 0. Reset mid-CALC discards the op.

## Timing
- Single-cycle op: out_valid rises on the accept edge and is visible in cycle N+1. Throughput is one per cycle while out_ready=1.
- Multiply/divide: out_valid rises WIDTH+2 edges after the accept edge (34 at WIDTH=32). in_ready is 0 throughout.
- An output transfer and a new accept may occur on the same edge.
- kill and rst are synchronous; kill has priority over accept and transfer, and rst over everything.
- in_ready, busy and all outputs are driven from registers. in_ready additionally depends combinationally on out_ready.

## Structure
- exe_pkg holds:
  - op codes and branch_cntr codes as named constants
  - alua_sel/alub_sel encodings
  - FSM state typedef (IDLE, CALC, FIN)
- Sub-module exe_muldiv holds the iterative multiply/divide datapath, counter and sign handling, with start/done handshake.
- exe_stage holds the operand muxes, single-cycle ALU, branch compare, output registers and handshake.

## Test plan
- ADD, rd1=0x7FFFFFFF, b=imm=1 → result 0x80000000, out_valid next cycle. SRA of 0x80000000 by rd2=0x21 (masked to 1) → 0xC0000000.
- BLTU rd1=1, rd2=0xFFFFFFFF → pcbranch 1. BLT with the same operands → pcbranch 0. branch_target = pc+imm with wrap from pc=0xFFFFFFFC, imm=8 → 0x4.
- MULH, 0x80000000 × 0x80000000 → 0x40000000, out_valid exactly 34 edges after accept, in_ready 0 and busy 1 throughout.
- DIV 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0.
- Hold out_ready=0 for 3 cycles after a result → outputs stable and in_ready 0. Releasing out_ready with in_valid=1 transfers and accepts on the same edge.
- kill at CALC cycle 10 → busy 0 and out_valid stays 0; next op accepted the following cycle. rst asserted with out_valid=1 → all outputs 0 next cycle.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the RV32IM execute stage: op codes, branch and operand
// select codes, and the multiply/divide FSM state type.
package exe_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    // Multiply/divide function code as seen by the iterative unit (op[2:0]).
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [2:0] BR_NONE   = 3'd0;
    localparam logic [2:0] BR_BEQ    = 3'd1;
    localparam logic [2:0] BR_BNE    = 3'd2;
    localparam logic [2:0] BR_BLT    = 3'd3;
    localparam logic [2:0] BR_BGE    = 3'd4;
    localparam logic [2:0] BR_BLTU   = 3'd5;
    localparam logic [2:0] BR_BGEU   = 3'd6;
    localparam logic [2:0] BR_NONE7  = 3'd7;

    localparam logic [1:0] ASEL_RD1  = 2'b00;
    localparam logic [1:0] ASEL_ZERO = 2'b01;
    localparam logic [1:0] ASEL_PC   = 2'b10;

    localparam logic [1:0] BSEL_RD2  = 2'b00;
    localparam logic [1:0] BSEL_SHM  = 2'b01;
    localparam logic [1:0] BSEL_IMM  = 2'b10;
    localparam logic [1:0] BSEL_FOUR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Operand/result bundle between register-read, the execute stage and writeback.
interface exe_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [1:0]       alua_sel;
    logic [1:0]       alub_sel;
    logic [4:0]       op;
    logic [2:0]       branch_cntr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             pcbranch;
    logic [WIDTH-1:0] branch_target;
    logic             busy;

    modport master (
        output in_valid, pc, rd1, rd2, imm, alua_sel, alub_sel, op, branch_cntr, out_ready,
        input  in_ready, out_valid, result, pcbranch, branch_target, busy
    );

    modport slave (
        input  in_valid, pc, rd1, rd2, imm, alua_sel, alub_sel, op, branch_cntr, out_ready,
        output in_ready, out_valid, result, pcbranch, branch_target, busy
    );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit: sign-magnitude conversion, one shift-add or
// restoring-subtract step per cycle, then sign fix-up and result selection.
module exe_muldiv
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             start,
    input  logic [2:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    state_e             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   a_r;
    logic [2:0]         fn_r;
    logic               neg_r;
    logic               div_zero_r;

    logic               sa_s, sb_s, neg_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH+1:0]   div_trial_s;
    logic [2*WIDTH-1:0] step_s, prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s, rem_fix_s, res_s;

    // Operand signedness and magnitudes captured at start.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (fn)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                sa_s = a[WIDTH-1];
                sb_s = b[WIDTH-1];
            end
            MD_MULHSU: begin
                sa_s = a[WIDTH-1];
                sb_s = 1'b0;
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
        if (sa_s) begin
            mag_a_s = -a;
        end else begin
            mag_a_s = a;
        end
        if (sb_s) begin
            mag_b_s = -b;
        end else begin
            mag_b_s = b;
        end
        // A remainder takes the dividend's sign; everything else the XOR.
        if (fn[2] && fn[1]) begin
            neg_s = sa_s;
        end else begin
            neg_s = sa_s ^ sb_s;
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {1'b0, prod_r[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_r};
        if (fn_r[2]) begin
            if (!div_trial_s[WIDTH+1]) begin
                step_s = {div_trial_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {prod_r[2*WIDTH-2:WIDTH-1], prod_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        end
    end

    // Sign correction and selection of the requested half / quotient / remainder.
    always_comb begin
        prod_fix_s = neg_r ? -prod_r : prod_r;
        quot_fix_s = neg_r ? -prod_r[WIDTH-1:0] : prod_r[WIDTH-1:0];
        rem_fix_s  = neg_r ? -prod_r[2*WIDTH-1:WIDTH] : prod_r[2*WIDTH-1:WIDTH];
        case (fn_r)
            MD_MUL:                        res_s = prod_fix_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  res_s = prod_fix_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:               res_s = div_zero_r ? {WIDTH{1'b1}} : quot_fix_s;
            MD_REM, MD_REMU:               res_s = div_zero_r ? a_r : rem_fix_s;
            default:                       res_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next state; kill returns to IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        if (kill) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = start ? CALC : IDLE;
                CALC:    state_s = (cnt_r == {CNT_W{1'b0}}) ? FIN : CALC;
                FIN:     state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: load on start, step while the counter runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            prod_r     <= {(2*WIDTH){1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            fn_r       <= 3'd0;
            neg_r      <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (state_r == IDLE && start && !kill) begin
            cnt_r      <= CNT_W'(WIDTH);
            prod_r     <= {{WIDTH{1'b0}}, mag_a_s};
            opnd_r     <= mag_b_s;
            a_r        <= a;
            fn_r       <= fn;
            neg_r      <= neg_s;
            div_zero_r <= (b == {WIDTH{1'b0}});
        end else if (state_r == CALC && cnt_r != {CNT_W{1'b0}}) begin
            prod_r <= step_s;
            cnt_r  <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign busy = (state_r != IDLE);
    assign done = (state_r == FIN);
    assign res  = res_s;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand muxes, single-cycle ALU, branch resolution and the
// registered output handshake; multiply/divide is delegated to exe_muldiv.
module exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill,
    exe_stage_if.slave  bus
);
    localparam int               SH_W       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SH_MASK    = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CONST_FOUR = WIDTH'(4);

    logic [WIDTH-1:0] a_s, b_s, alu_s, bt_s, md_res_s;
    logic [SH_W-1:0]  shamt_s;
    logic             branch_s, in_ready_s, accept_s, md_start_s, md_busy_s, md_done_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             pcbranch_r;
    logic [WIDTH-1:0] branch_target_r;

    // Operand selection.
    always_comb begin
        case (bus.alua_sel)
            ASEL_ZERO: a_s = {WIDTH{1'b0}};
            ASEL_PC:   a_s = bus.pc;
            default:   a_s = bus.rd1;
        endcase
        case (bus.alub_sel)
            BSEL_RD2:  b_s = bus.rd2;
            BSEL_SHM:  b_s = bus.rd2 & SH_MASK;
            BSEL_IMM:  b_s = bus.imm;
            BSEL_FOUR: b_s = CONST_FOUR;
            default:   b_s = bus.rd2;
        endcase
        shamt_s = b_s[SH_W-1:0];
        bt_s    = bus.pc + bus.imm;
    end

    // Single-cycle ALU; unused op codes yield zero.
    always_comb begin
        case (bus.op)
            OP_ADD:  alu_s = a_s + b_s;
            OP_SUB:  alu_s = a_s - b_s;
            OP_SLL:  alu_s = a_s << shamt_s;
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_XOR:  alu_s = a_s ^ b_s;
            OP_SRL:  alu_s = a_s >> shamt_s;
            OP_SRA:  alu_s = $unsigned($signed(a_s) >>> shamt_s);
            OP_OR:   alu_s = a_s | b_s;
            OP_AND:  alu_s = a_s & b_s;
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Branch compare works on the raw register values, not the muxed operands.
    always_comb begin
        case (bus.branch_cntr)
            BR_BEQ:  branch_s = (bus.rd1 == bus.rd2);
            BR_BNE:  branch_s = (bus.rd1 != bus.rd2);
            BR_BLT:  branch_s = ($signed(bus.rd1) < $signed(bus.rd2));
            BR_BGE:  branch_s = ($signed(bus.rd1) >= $signed(bus.rd2));
            BR_BLTU: branch_s = (bus.rd1 < bus.rd2);
            BR_BGEU: branch_s = (bus.rd1 >= bus.rd2);
            default: branch_s = 1'b0;
        endcase
    end

    assign in_ready_s = !rst && !md_busy_s && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s && !kill;
    assign md_start_s = accept_s && is_muldiv(bus.op);

    exe_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .kill  (kill),
        .start (md_start_s),
        .fn    (bus.op[2:0]),
        .a     (a_s),
        .b     (b_s),
        .busy  (md_busy_s),
        .done  (md_done_s),
        .res   (md_res_s)
    );

    // Output registers: rst, then kill, then completion/accept, then transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r     <= 1'b0;
            result_r        <= {WIDTH{1'b0}};
            pcbranch_r      <= 1'b0;
            branch_target_r <= {WIDTH{1'b0}};
        end else if (kill) begin
            out_valid_r <= 1'b0;
        end else if (md_done_s) begin
            result_r    <= md_res_s;
            pcbranch_r  <= 1'b0;
            out_valid_r <= 1'b1;
        end else if (accept_s && !is_muldiv(bus.op)) begin
            result_r        <= alu_s;
            pcbranch_r      <= branch_s;
            branch_target_r <= bt_s;
            out_valid_r     <= 1'b1;
        end else if (accept_s) begin
            // Multi-cycle op: any previous result transfers this edge.
            pcbranch_r      <= 1'b0;
            branch_target_r <= bt_s;
            out_valid_r     <= 1'b0;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.result        = result_r;
    assign bus.pcbranch      = pcbranch_r;
    assign bus.branch_target = branch_target_r;
    assign bus.busy          = md_busy_s;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors push expected results, and a
// monitor pops and compares on every output transfer.
module tb_exe_stage;
    import exe_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        pcb;
        logic [31:0] bt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic kill;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    exe_stage_if #(.WIDTH(32)) bus ();

    exe_stage #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .kill (kill),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Issue one op and return #1 after the edge that accepted it.
    task automatic issue(input string nm, input logic [4:0] op, input logic [1:0] as,
                         input logic [1:0] bs, input logic [2:0] bc, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] er, input logic ep, input bit push);
        int guard;
        exp_t e;
        if (push) begin
            e.name = nm;
            e.res  = er;
            e.pcb  = ep;
            e.bt   = pc + im;
            exp_q.push_back(e);
        end
        bus.op = op; bus.alua_sel = as; bus.alub_sel = bs; bus.branch_cntr = bc;
        bus.pc = pc; bus.rd1 = r1; bus.rd2 = r2; bus.imm = im;
        bus.in_valid = 1'b1;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL %s_accept_timeout: in_ready stayed 0, required 1", nm);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare each result transferred downstream.
    always @(negedge clk) begin
        if (!rst && !kill && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output: got result %h, required no output", bus.result);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_result"}, bus.result, mon_e.res);
                chk({mon_e.name, "_pcbranch"}, 32'(bus.pcbranch), 32'(mon_e.pcb));
                chk({mon_e.name, "_target"}, bus.branch_target, mon_e.bt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  bad;
        rst = 1'b1; kill = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = 5'd0; bus.alua_sel = 2'd0; bus.alub_sel = 2'd0; bus.branch_cntr = 3'd0;
        bus.pc = 32'd0; bus.rd1 = 32'd0; bus.rd2 = 32'd0; bus.imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_pcbranch", 32'(bus.pcbranch), 32'd0);
        chk("rst_target", bus.branch_target, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Single-cycle ops, back to back.
        issue("add_ovf", OP_ADD, ASEL_RD1, BSEL_IMM, BR_NONE, 32'h100, 32'h7FFFFFFF, 32'h0, 32'h1, 32'h80000000, 1'b0, 1'b1);
        chk("add_out_valid_next", 32'(bus.out_valid), 32'd1);
        issue("sra_mask", OP_SRA, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'h80000000, 32'h21, 32'h0, 32'hC0000000, 1'b0, 1'b1);
        issue("sll_shm", OP_SLL, ASEL_RD1, BSEL_SHM, BR_NONE, 32'h10, 32'h1, 32'h25, 32'h4, 32'h20, 1'b0, 1'b1);
        issue("bltu", OP_ADD, ASEL_RD1, BSEL_RD2, BR_BLTU, 32'hFFFFFFFC, 32'h1, 32'hFFFFFFFF, 32'h8, 32'h0, 1'b1, 1'b1);
        issue("blt", OP_ADD, ASEL_RD1, BSEL_RD2, BR_BLT, 32'hFFFFFFFC, 32'h1, 32'hFFFFFFFF, 32'h8, 32'h0, 1'b0, 1'b1);
        issue("slt", OP_SLT, ASEL_RD1, BSEL_RD2, BR_BNE, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b1, 1'b1);
        issue("sltu", OP_SLTU, ASEL_RD1, BSEL_RD2, BR_BGEU, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1);
        issue("pc_plus4", OP_ADD, ASEL_PC, BSEL_FOUR, BR_NONE7, 32'h1000, 32'h5, 32'h6, 32'h0, 32'h1004, 1'b0, 1'b1);
        issue("zero_imm_or", OP_OR, ASEL_ZERO, BSEL_IMM, BR_BGE, 32'h0, 32'h9, 32'h9, 32'h55, 32'h55, 1'b1, 1'b1);
        issue("illegal_op", 5'd12, ASEL_RD1, BSEL_RD2, BR_BEQ, 32'h0, 32'h3, 32'h3, 32'h0, 32'h0, 1'b1, 1'b1);

        // MULH latency, busy and in_ready while calculating.
        issue("mulh_min", OP_MULH, ASEL_RD1, BSEL_RD2, BR_BEQ, 32'h40, 32'h80000000, 32'h80000000, 32'h4, 32'h40000000, 1'b0, 1'b1);
        lat = 0; bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (!bus.busy || bus.in_ready) bad = 1'b1;
        end
        chk("mulh_latency", 32'(lat), 32'd34);
        chk("mulh_busy_no_ready", 32'(bad), 32'd0);

        issue("mul_neg", OP_MUL, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'h3, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFA, 1'b0, 1'b1);
        issue("mulhu", OP_MULHU, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b1);
        issue("mulhsu", OP_MULHSU, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue("divu", OP_DIVU, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'd100, 32'd7, 32'h0, 32'd14, 1'b0, 1'b1);
        issue("div_neg", OP_DIV, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFD, 1'b0, 1'b1);
        issue("rem_neg", OP_REM, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue("div_by0", OP_DIV, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'd5, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue("rem_by0", OP_REM, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'd5, 32'd0, 32'h0, 32'd5, 1'b0, 1'b1);
        issue("div_ovf", OP_DIV, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b1);
        issue("rem_ovf", OP_REM, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue("divu_by0", OP_DIVU, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'h80000005, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (2) @(posedge clk);
        #1;

        // Output hold under backpressure, then transfer and accept on one edge.
        bus.out_ready = 1'b0;
        issue("hold_add", OP_ADD, ASEL_RD1, BSEL_RD2, BR_BNE, 32'h20, 32'd2, 32'd3, 32'h4, 32'd5, 1'b1, 1'b1);
        bus.op = OP_SUB; bus.alua_sel = ASEL_RD1; bus.alub_sel = BSEL_RD2; bus.branch_cntr = BR_NONE;
        bus.pc = 32'h30; bus.rd1 = 32'd10; bus.rd2 = 32'd3; bus.imm = 32'h4;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("hold_result", bus.result, 32'd5);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("hold_target", bus.branch_target, 32'h24);
        exp_q.push_back('{name: "hold_sub", res: 32'd7, pcb: 1'b0, bt: 32'h34});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd1);
        chk("release_result", bus.result, 32'd7);
        @(posedge clk); #1;

        // Kill in the middle of a divide, with a competing input that cycle.
        issue("killed_div", OP_DIV, ASEL_RD1, BSEL_RD2, BR_NONE, 32'h0, 32'd100, 32'd3, 32'h0, 32'd33, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("kill_pre_busy", 32'(bus.busy), 32'd1);
        kill = 1'b1;
        bus.op = OP_ADD; bus.alua_sel = ASEL_RD1; bus.alub_sel = BSEL_RD2; bus.branch_cntr = BR_NONE;
        bus.rd1 = 32'h11; bus.rd2 = 32'h22;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        bus.in_valid = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_out_valid", 32'(bus.out_valid), 32'd0);
        chk("kill_in_ready", 32'(bus.in_ready), 32'd1);
        issue("post_kill", OP_ADD, ASEL_RD1, BSEL_RD2, BR_BEQ, 32'h8, 32'd1, 32'd1, 32'h8, 32'd2, 1'b1, 1'b1);
        chk("post_kill_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (40) @(posedge clk);
        #1;

        // Reset with a result pending downstream.
        bus.out_ready = 1'b0;
        issue("rst_pending", OP_ADD, ASEL_RD1, BSEL_RD2, BR_BEQ, 32'h200, 32'd5, 32'd5, 32'h10, 32'd10, 1'b1, 1'b0);
        chk("rst_pend_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_result", bus.result, 32'd0);
        chk("rst2_pcbranch", 32'(bus.pcbranch), 32'd0);
        chk("rst2_target", bus.branch_target, 32'd0);
        chk("rst2_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
